// File: rtl/multi_digit_counter.sv
// N-digit cascaded up/down counter with per-digit BCD/hex radix, parallel load
// and an enable prescaler; feeds the multi-digit seven-segment display path.
module multi_digit_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1,
  parameter int PS_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sel,
  input  logic                    updown,
  input  logic                    load_button,
  input  logic [4*NUM_DIGITS-1:0] load,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    carry,
  output logic                    zero
);

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic                    r_carry;
  logic [PS_W-1:0]         r_ps;

  logic [4*NUM_DIGITS-1:0] w_step;
  logic [4*NUM_DIGITS-1:0] w_load_val;
  logic [NUM_DIGITS:0]     w_chain;
  logic [3:0]              w_max;
  logic                    w_ps_done;

  assign w_max     = sel ? 4'd9 : 4'hF;
  assign w_ps_done = (r_ps == PS_W'(PRESCALE - 1));

  // w_chain[i] is the carry (up) or borrow (down) entering digit i. In BCD an
  // out-of-range nibble (A-F) is treated as "at max" going up, so it wraps to 0
  // and carries; going down it lands on 9 without borrowing.
  always_comb begin
    w_step     = r_digits;
    w_load_val = load;
    w_chain    = '0;
    w_chain[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (updown) begin
        if (w_chain[i])
          w_step[4*i +: 4] = (r_digits[4*i +: 4] >= w_max) ? 4'd0 : r_digits[4*i +: 4] + 4'd1;
        w_chain[i+1] = w_chain[i] && (r_digits[4*i +: 4] >= w_max);
      end else begin
        if (w_chain[i]) begin
          if (r_digits[4*i +: 4] == 4'd0)
            w_step[4*i +: 4] = w_max;
          else if (sel && (r_digits[4*i +: 4] > 4'd9))
            w_step[4*i +: 4] = 4'd9;
          else
            w_step[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
        end
        w_chain[i+1] = w_chain[i] && (r_digits[4*i +: 4] == 4'd0);
      end
      if (sel && (load[4*i +: 4] > 4'd9))
        w_load_val[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits <= '0;
      r_carry  <= 1'b0;
      r_ps     <= '0;
    end else if (load_button) begin
      r_digits <= w_load_val;
      r_carry  <= 1'b0;
      r_ps     <= '0;
    end else if (en) begin
      if (w_ps_done) begin
        r_ps     <= '0;
        r_digits <= w_step;
        r_carry  <= w_chain[NUM_DIGITS];
      end else begin
        r_ps    <= r_ps + 1'b1;
        r_carry <= 1'b0;
      end
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign digits = r_digits;
  assign carry  = r_carry;
  assign zero   = (r_digits == '0);

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench for multi_digit_counter: two 2-digit instances, one stepping
// every enabled cycle (a_*) and one with a divide-by-3 prescaler (b_*).
module tb_multi_digit_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sel;
  logic       updown;
  logic       load_button;
  logic [7:0] load;

  logic [7:0] a_digits, b_digits;
  logic       a_carry, b_carry, a_zero, b_zero;

  int errors = 0;
  int checks = 0;

  multi_digit_counter #(.NUM_DIGITS(2), .PRESCALE(1), .PS_W(16)) u_a (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .updown(updown),
    .load_button(load_button), .load(load),
    .digits(a_digits), .carry(a_carry), .zero(a_zero)
  );

  multi_digit_counter #(.NUM_DIGITS(2), .PRESCALE(3), .PS_W(16)) u_b (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .updown(updown),
    .load_button(load_button), .load(load),
    .digits(b_digits), .carry(b_carry), .zero(b_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] val, input logic s);
    sel         = s;
    en          = 1'b0;
    load        = val;
    load_button = 1'b1;
    tick();
    load_button = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; sel = 1'b1; updown = 1'b1; load_button = 1'b0; load = 8'h00;
    tick(3);
    checks++; if (a_digits !== 8'h00) begin errors++; $display("FAIL reset_a_digits got=%h exp=00", a_digits); end
    checks++; if (a_carry !== 1'b0)   begin errors++; $display("FAIL reset_a_carry got=%b exp=0", a_carry); end
    checks++; if (a_zero !== 1'b1)    begin errors++; $display("FAIL reset_a_zero got=%b exp=1", a_zero); end
    checks++; if (b_digits !== 8'h00) begin errors++; $display("FAIL reset_b_digits got=%h exp=00", b_digits); end
  endtask

  task automatic test_bcd_full;
    rst = 1'b1; sel = 1'b1; updown = 1'b1; en = 1'b1;
    tick(99);
    checks++; if (a_digits !== 8'h99) begin errors++; $display("FAIL bcd_99_digits got=%h exp=99", a_digits); end
    checks++; if (a_carry !== 1'b0)   begin errors++; $display("FAIL bcd_99_carry got=%b exp=0", a_carry); end
    tick();
    checks++; if (a_digits !== 8'h00) begin errors++; $display("FAIL bcd_wrap_digits got=%h exp=00", a_digits); end
    checks++; if (a_carry !== 1'b1)   begin errors++; $display("FAIL bcd_wrap_carry got=%b exp=1", a_carry); end
    checks++; if (a_zero !== 1'b1)    begin errors++; $display("FAIL bcd_wrap_zero got=%b exp=1", a_zero); end
    tick();
    checks++; if (a_carry !== 1'b0)   begin errors++; $display("FAIL bcd_carry_pulse got=%b exp=0", a_carry); end
    checks++; if (a_digits !== 8'h01) begin errors++; $display("FAIL bcd_after_wrap got=%h exp=01", a_digits); end
    en = 1'b0;
  endtask

  task automatic test_hex_down;
    do_load(8'h00, 1'b0);
    updown = 1'b0; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'hFF) begin errors++; $display("FAIL hex_down_wrap got=%h exp=FF", a_digits); end
    checks++; if (a_carry !== 1'b1)   begin errors++; $display("FAIL hex_down_carry got=%b exp=1", a_carry); end
    tick();
    checks++; if (a_digits !== 8'hFE) begin errors++; $display("FAIL hex_down_fe got=%h exp=FE", a_digits); end
    checks++; if (a_carry !== 1'b0)   begin errors++; $display("FAIL hex_down_carry2 got=%b exp=0", a_carry); end
    checks++; if (a_zero !== 1'b0)    begin errors++; $display("FAIL hex_down_zero got=%b exp=0", a_zero); end
    do_load(8'hFF, 1'b0);
    updown = 1'b1; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'h00 || a_carry !== 1'b1) begin errors++; $display("FAIL hex_up_wrap got=%h/%b exp=00/1", a_digits, a_carry); end
    do_load(8'h10, 1'b0);
    updown = 1'b0; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'h0F) begin errors++; $display("FAIL hex_borrow got=%h exp=0F", a_digits); end
    en = 1'b0;
  endtask

  task automatic test_bcd_ripple;
    do_load(8'h19, 1'b1);
    updown = 1'b1; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'h20) begin errors++; $display("FAIL bcd_ripple got=%h exp=20", a_digits); end
    do_load(8'h00, 1'b1);
    updown = 1'b0; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'h99 || a_carry !== 1'b1) begin errors++; $display("FAIL bcd_down_wrap got=%h/%b exp=99/1", a_digits, a_carry); end
    do_load(8'hAF, 1'b1);
    checks++; if (a_digits !== 8'h99) begin errors++; $display("FAIL bcd_clamp got=%h exp=99", a_digits); end
    checks++; if (a_carry !== 1'b0)   begin errors++; $display("FAIL load_carry got=%b exp=0", a_carry); end
    do_load(8'hA3, 1'b1);
    checks++; if (a_digits !== 8'h93) begin errors++; $display("FAIL bcd_clamp_hi got=%h exp=93", a_digits); end
    do_load(8'hAF, 1'b0);
    checks++; if (a_digits !== 8'hAF) begin errors++; $display("FAIL hex_noclamp got=%h exp=AF", a_digits); end
  endtask

  task automatic test_prescale;
    do_load(8'h00, 1'b1);
    updown = 1'b1; en = 1'b1;
    tick(2);
    checks++; if (b_digits !== 8'h00) begin errors++; $display("FAIL ps_edge2 got=%h exp=00", b_digits); end
    tick();
    checks++; if (b_digits !== 8'h01) begin errors++; $display("FAIL ps_edge3 got=%h exp=01", b_digits); end
    tick(2);
    checks++; if (b_digits !== 8'h01) begin errors++; $display("FAIL ps_edge5 got=%h exp=01", b_digits); end
    tick();
    checks++; if (b_digits !== 8'h02) begin errors++; $display("FAIL ps_edge6 got=%h exp=02", b_digits); end
    tick(3);
    checks++; if (b_digits !== 8'h03) begin errors++; $display("FAIL ps_edge9 got=%h exp=03", b_digits); end
    // enable dropout: step 2 moves from edge 6 to edge 8
    do_load(8'h00, 1'b1);
    en = 1'b1;
    tick(4);
    en = 1'b0;
    tick(2);
    checks++; if (b_digits !== 8'h01) begin errors++; $display("FAIL ps_hold got=%h exp=01", b_digits); end
    en = 1'b1;
    tick();
    checks++; if (b_digits !== 8'h01) begin errors++; $display("FAIL ps_resume1 got=%h exp=01", b_digits); end
    tick();
    checks++; if (b_digits !== 8'h02) begin errors++; $display("FAIL ps_resume2 got=%h exp=02", b_digits); end
    en = 1'b0;
  endtask

  task automatic test_load_priority;
    do_load(8'h00, 1'b1);
    updown = 1'b1; en = 1'b1;
    tick();
    load = 8'h42; load_button = 1'b1;
    tick();
    load_button = 1'b0;
    checks++; if (a_digits !== 8'h42 || a_carry !== 1'b0) begin errors++; $display("FAIL load_en_a got=%h/%b exp=42/0", a_digits, a_carry); end
    checks++; if (b_digits !== 8'h42) begin errors++; $display("FAIL load_en_b got=%h exp=42", b_digits); end
    tick(2);
    checks++; if (b_digits !== 8'h42) begin errors++; $display("FAIL ps_restart_hold got=%h exp=42", b_digits); end
    checks++; if (a_digits !== 8'h44) begin errors++; $display("FAIL after_load_a got=%h exp=44", a_digits); end
    tick();
    checks++; if (b_digits !== 8'h43) begin errors++; $display("FAIL ps_restart_step got=%h exp=43", b_digits); end
  endtask

  task automatic test_async_reset;
    en = 1'b1;
    tick(2);
    #2 rst = 1'b0;
    #1;
    checks++; if (a_digits !== 8'h00) begin errors++; $display("FAIL async_rst_a got=%h exp=00", a_digits); end
    checks++; if (b_digits !== 8'h00) begin errors++; $display("FAIL async_rst_b got=%h exp=00", b_digits); end
    checks++; if (a_zero !== 1'b1)    begin errors++; $display("FAIL async_rst_zero got=%b exp=1", a_zero); end
    tick();
    rst = 1'b1;
    en  = 1'b0;
  endtask

  task automatic test_radix_switch;
    do_load(8'h0C, 1'b0);
    sel = 1'b1; updown = 1'b1; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'h10) begin errors++; $display("FAIL radix_up got=%h exp=10", a_digits); end
    do_load(8'h0C, 1'b0);
    sel = 1'b1; updown = 1'b0; en = 1'b1;
    tick();
    checks++; if (a_digits !== 8'h09) begin errors++; $display("FAIL radix_down got=%h exp=09", a_digits); end
    checks++; if (a_carry !== 1'b0)   begin errors++; $display("FAIL radix_down_carry got=%b exp=0", a_carry); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bcd_full();
    test_hex_down();
    test_bcd_ripple();
    test_prescale();
    test_load_priority();
    test_async_reset();
    test_radix_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
